// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
//
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits. Each
// digit shows the glyph of a 3-bit user code. A prescaler sets how long each
// digit slot lasts. The first cycle of every slot is a blanked dead time, so the
// previous digit's segments never ghost onto the next anode. User codes are
// double-buffered: a Load goes into a shadow register, and that register is
// copied to the displayed (active) register only at a frame boundary. A frame
// therefore never shows a mix of old and new codes. Invalid codes blink with a
// period of 2*BLINK_DIV frames.
//
// Ports
//   Clock       in   system clock
//   Reset_n     in   synchronous reset, active low
//   Users       in   3*NUM_DIGITS user codes, digit k = Users[3k+2:3k]
//   Load        in   single-cycle strobe, captures Users
//   Enable      in   0 blanks all digits; counters and buffering keep running
//   A..G        out  segment drives, active low (0 = lit)
//   DP          out  decimal point, always off (1)
//   Digit_n     out  NUM_DIGITS anode strobes, active low, one-hot-cold
//   Frame_done  out  one-cycle pulse after the last digit slot of a frame ends
// -----------------------------------------------------------------------------
module display_scanner #(
   parameter int NUM_DIGITS = 4,     // 1..8
   parameter int PRESCALE   = 1000,  // clock cycles per digit slot, >= 2
   parameter int BLINK_DIV  = 256    // frames per blink half-period, >= 1
) (
   input  logic                      Clock,
   input  logic                      Reset_n,
   input  logic [3*NUM_DIGITS-1:0]   Users,
   input  logic                      Load,
   input  logic                      Enable,
   output logic                      A,
   output logic                      B,
   output logic                      C,
   output logic                      D,
   output logic                      E,
   output logic                      F,
   output logic                      G,
   output logic                      DP,
   output logic [NUM_DIGITS-1:0]     Digit_n,
   output logic                      Frame_done
);

   localparam int PW = $clog2(PRESCALE);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   // Segment patterns as {A,B,C,D,E,F,G}, active low.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_U     = 7'b1000001;
   localparam logic [6:0] SEG_T     = 7'b1110000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_G     = 7'b0100001;
   localparam logic [6:0] SEG_F     = 7'b0111000;

   typedef enum logic [2:0] {
      CODE_BLANK0 = 3'b000,
      CODE_U      = 3'b001,
      CODE_BAD2   = 3'b010,
      CODE_T      = 3'b011,
      CODE_BAD4   = 3'b100,
      CODE_A      = 3'b101,
      CODE_G      = 3'b110,
      CODE_BLANK7 = 3'b111
   } code_e;

   // Scan and blink state
   logic [PW-1:0]             r_presc;
   logic [IW-1:0]             r_idx;
   logic [BW-1:0]             r_blink_cnt;
   logic                      r_blink_phase;

   // Code buffering
   logic [3*NUM_DIGITS-1:0]   r_shadow;
   logic [3*NUM_DIGITS-1:0]   r_active;
   logic                      r_pending;

   // Registered outputs
   logic [6:0]                r_seg;
   logic [NUM_DIGITS-1:0]     r_digit_n;
   logic                      r_frame_done;

   // Combinational helpers
   logic                      w_presc_end;
   logic                      w_frame_wrap;
   logic [2:0]                w_code;
   logic [6:0]                w_glyph;
   logic [6:0]                w_seg_next;
   logic [NUM_DIGITS-1:0]     w_digit_next;

   // NOTE: every signal written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_presc_end  = (r_presc == PRESC_MAX);
      w_frame_wrap = w_presc_end && (r_idx == IDX_MAX);

      // Select the code of the digit being scanned.
      w_code = 3'b000;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_code = r_active[3*k +: 3];
         end
      end

      w_glyph = SEG_BLANK;
      case (w_code)
         CODE_BLANK0, CODE_BLANK7: w_glyph = SEG_BLANK;
         CODE_U:                   w_glyph = SEG_U;
         CODE_T:                   w_glyph = SEG_T;
         CODE_A:                   w_glyph = SEG_A;
         CODE_G:                   w_glyph = SEG_G;
         // Invalid codes (010, 100): F in blink phase 0, blank in phase 1.
         default:                  w_glyph = r_blink_phase ? SEG_BLANK : SEG_F;
      endcase

      // Slot cycle 0 is dead time: anodes off and segments dark, so the new
      // anode never lights with the previous digit's segments.
      w_seg_next   = SEG_BLANK;
      w_digit_next = '1;
      if (r_presc != '0) begin
         w_seg_next = w_glyph;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
               w_digit_next[k] = 1'b0;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         // NOTE: the code registers are reset with the rest of the state, so the
         // display comes up blank and a pending load from before reset is dropped.
         r_presc       <= '0;
         r_idx         <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_shadow      <= '0;
         r_active      <= '0;
         r_pending     <= 1'b0;
         r_seg         <= SEG_BLANK;
         r_digit_n     <= '1;
         r_frame_done  <= 1'b0;
      end else begin
         // Scan counters
         r_presc <= w_presc_end ? '0 : r_presc + 1'b1;
         if (w_presc_end) begin
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
         end

         // Blink divider, advanced once per frame
         if (w_frame_wrap) begin
            if (r_blink_cnt == BLINK_MAX) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end

         // Double buffering. A load that lands on the wrap edge bypasses the
         // shadow, so it shows in the very next frame instead of one frame later.
         if (Load && w_frame_wrap) begin
            r_shadow  <= Users;
            r_active  <= Users;
            r_pending <= 1'b0;
         end else if (Load) begin
            r_shadow  <= Users;
            r_pending <= 1'b1;
         end else if (w_frame_wrap && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
         end

         // Registered outputs, one cycle behind the scan state
         r_frame_done <= w_frame_wrap;
         if (Enable) begin
            r_seg     <= w_seg_next;
            r_digit_n <= w_digit_next;
         end else begin
            r_seg     <= SEG_BLANK;
            r_digit_n <= '1;
         end
      end
   end

   assign {A, B, C, D, E, F, G} = r_seg;
   assign DP                    = 1'b1;
   assign Digit_n               = r_digit_n;
   assign Frame_done            = r_frame_done;

endmodule
